// File: rtl/parity_pkg.sv
// Shared types and constants for the 4-bit parity serial receiver.
package parity_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int ERR_CNT_W = 8;
    localparam int CNT_W     = $clog2(NIBBLE_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } rx_state_t;

    // True when the received nibble plus parity bit disagree with the selected sense.
    function automatic logic parity_mismatch(
        input logic [NIBBLE_W-1:0] nibble,
        input logic                pbit,
        input logic                odd
    );
        return ((^nibble) ^ pbit) != odd;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value selectable.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {2{RST_VAL}};
        end else begin
            sync_reg <= {sync_reg[0], din};
        end
    end

    assign dout = sync_reg[1];

endmodule

// File: rtl/parity_rx4.sv
// Serial receiver: start, 4 data bits LSB first, parity, stop; one bit per bit_en strobe.
// Optional saturating error counter output err_cnt when ERR_CNT_EN is defined.
module parity_rx4
    import parity_pkg::*;
#(
    parameter bit PARITY_ODD = 1'b0,
    parameter bit STOP_CHK   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bit_en,
    input  logic                sin,
    output logic [NIBBLE_W-1:0] data,
    output logic                valid,
    output logic                par_err,
    output logic                frm_err,
    output logic                led
`ifdef ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    logic s_sin;

    rx_state_t              state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [NIBBLE_W-1:0]    shift_reg, shift_next;
    logic                   pbit_reg, pbit_next;
    logic [NIBBLE_W-1:0]    data_reg;
    logic                   led_reg;
    logic                   valid_reg, valid_next;
    logic                   par_err_reg, par_err_next;
    logic                   frm_err_reg, frm_err_next;
    logic                   stop_ok;
    logic                   mismatch;

    sync2 #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sin),
        .dout (s_sin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
            pbit_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
            pbit_reg  <= pbit_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (bit_en) begin
            case (state_reg)
                IDLE:    if (!s_sin) state_next = DATA;
                DATA:    if (cnt_reg == CNT_W'(NIBBLE_W - 1)) state_next = PAR;
                PAR:     state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        pbit_next  = pbit_reg;
        if (bit_en) begin
            case (state_reg)
                IDLE: if (!s_sin) cnt_next = '0;
                DATA: begin
                    shift_next[cnt_reg] = s_sin;
                    cnt_next            = cnt_reg + CNT_W'(1);
                end
                PAR:  pbit_next = s_sin;
                default: ;
            endcase
        end
    end

    // A bad stop bit drops the frame, so it outranks any parity result.
    assign stop_ok  = s_sin || !STOP_CHK;
    assign mismatch = parity_mismatch(shift_reg, pbit_reg, PARITY_ODD);

    always_comb begin
        valid_next   = 1'b0;
        par_err_next = 1'b0;
        frm_err_next = 1'b0;
        if (bit_en && state_reg == STOP) begin
            if (!stop_ok) begin
                frm_err_next = 1'b1;
            end else if (mismatch) begin
                par_err_next = 1'b1;
            end else begin
                valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg    <= '0;
            led_reg     <= 1'b0;
            valid_reg   <= 1'b0;
            par_err_reg <= 1'b0;
            frm_err_reg <= 1'b0;
        end else begin
            valid_reg   <= valid_next;
            par_err_reg <= par_err_next;
            frm_err_reg <= frm_err_next;
            if (valid_next) begin
                data_reg <= shift_reg;
                led_reg  <= ^shift_reg;
            end
        end
    end

    assign data    = data_reg;
    assign led     = led_reg;
    assign valid   = valid_reg;
    assign par_err = par_err_reg;
    assign frm_err = frm_err_reg;

`ifdef ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if ((par_err_reg || frm_err_reg) && err_cnt_reg != '1) begin
            err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_parity_rx4.sv
// Directed bench for parity_rx4: even/default, odd-parity and stop-ignore instances.
module tb_parity_rx4;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       bit_en = 1'b0;
    logic [2:0] sin_v  = 3'b111;

    logic [3:0] data_a [3];
    logic [2:0] valid_v, par_v, frm_v, led_v;
`ifdef ERR_CNT_EN
    logic [7:0] cnt_a [3];
`endif

    int checks = 0;
    int errors = 0;

    logic       r_pre;
    logic [3:0] r_data;
    logic       r_valid, r_par, r_frm, r_led;
    logic [2:0] r_after;

    always #5 clk = ~clk;

    parity_rx4 u_even (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sin(sin_v[0]),
        .data(data_a[0]), .valid(valid_v[0]), .par_err(par_v[0]),
        .frm_err(frm_v[0]), .led(led_v[0])
`ifdef ERR_CNT_EN
        , .err_cnt(cnt_a[0])
`endif
    );

    parity_rx4 #(.PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sin(sin_v[1]),
        .data(data_a[1]), .valid(valid_v[1]), .par_err(par_v[1]),
        .frm_err(frm_v[1]), .led(led_v[1])
`ifdef ERR_CNT_EN
        , .err_cnt(cnt_a[1])
`endif
    );

    parity_rx4 #(.STOP_CHK(1'b0)) u_nostop (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sin(sin_v[2]),
        .data(data_a[2]), .valid(valid_v[2]), .par_err(par_v[2]),
        .frm_err(frm_v[2]), .led(led_v[2])
`ifdef ERR_CNT_EN
        , .err_cnt(cnt_a[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bit period: optional glitch, settle through the synchronizer, then a single strobe.
    task automatic send_bit(input int sel, input logic b, input logic glitch);
        @(negedge clk); sin_v[sel] = glitch ? ~b : b;
        @(negedge clk); sin_v[sel] = b;
        @(negedge clk);
        @(negedge clk); bit_en = 1'b1;
        @(negedge clk); bit_en = 1'b0;
    endtask

    task automatic send_frame(input int sel, input logic [3:0] nib, input logic pbit,
                              input logic sbit, input logic glitch);
        send_bit(sel, 1'b0, glitch);
        for (int i = 0; i < 4; i++) send_bit(sel, nib[i], glitch);
        send_bit(sel, pbit, glitch);
        r_pre = valid_v[sel] | par_v[sel] | frm_v[sel];
        send_bit(sel, sbit, glitch);
        r_data  = data_a[sel];
        r_valid = valid_v[sel];
        r_par   = par_v[sel];
        r_frm   = frm_v[sel];
        r_led   = led_v[sel];
        @(negedge clk);
        r_after = {valid_v[sel], par_v[sel], frm_v[sel]};
        sin_v[sel] = 1'b1;
        $display("frame dut%0d nib=%h p=%b s=%b -> valid=%b par_err=%b frm_err=%b data=%h led=%b",
                 sel, nib, pbit, sbit, r_valid, r_par, r_frm, r_data, r_led);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int pe, vl, fe;
        logic [6:0] fbits;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data",  data_a[0],  4'h0);
        chk("rst_led",   led_v[0],   1'b0);
        chk("rst_valid", valid_v[0], 1'b0);
        chk("rst_par",   par_v[0],   1'b0);
        chk("rst_frm",   frm_v[0],   1'b0);
`ifdef ERR_CNT_EN
        chk("rst_cnt",   cnt_a[0],   8'd0);
`endif
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Good even frame: d0..d3 = 1,0,1,1 -> 4'hD, parity 1
        send_frame(0, 4'hD, 1'b1, 1'b1, 1'b0);
        chk("t1_pre",   r_pre,   1'b0);
        chk("t1_valid", r_valid, 1'b1);
        chk("t1_par",   r_par,   1'b0);
        chk("t1_frm",   r_frm,   1'b0);
        chk("t1_data",  r_data,  4'hD);
        chk("t1_led",   r_led,   1'b1);
        chk("t1_after", r_after, 3'b000);

        // Same frame, wrong parity
        send_frame(0, 4'hD, 1'b0, 1'b1, 1'b0);
        chk("t2_par",   r_par,   1'b1);
        chk("t2_valid", r_valid, 1'b0);
        chk("t2_frm",   r_frm,   1'b0);
        chk("t2_data",  r_data,  4'hD);
        chk("t2_after", r_after, 3'b000);
`ifdef ERR_CNT_EN
        chk("t2_cnt",   cnt_a[0], 8'd1);
`endif

        // Good frame 4'h3 with glitches between strobes
        send_frame(0, 4'h3, 1'b0, 1'b1, 1'b1);
        chk("t3_valid", r_valid, 1'b1);
        chk("t3_data",  r_data,  4'h3);
        chk("t3_led",   r_led,   1'b0);

        // Bad stop with bad parity: framing error only
        send_frame(0, 4'hD, 1'b0, 1'b0, 1'b0);
        chk("t4_frm",   r_frm,   1'b1);
        chk("t4_par",   r_par,   1'b0);
        chk("t4_valid", r_valid, 1'b0);
        chk("t4_data",  r_data,  4'h3);
`ifdef ERR_CNT_EN
        chk("t4_cnt",   cnt_a[0], 8'd2);
`endif

        // Stop check disabled: bad stop still yields valid
        send_frame(2, 4'hD, 1'b1, 1'b0, 1'b0);
        chk("t5_valid", r_valid, 1'b1);
        chk("t5_frm",   r_frm,   1'b0);
        chk("t5_data",  r_data,  4'hD);

        // Odd parity instance
        send_frame(1, 4'h5, 1'b1, 1'b1, 1'b0);
        chk("t6_valid", r_valid, 1'b1);
        chk("t6_data",  r_data,  4'h5);
        send_frame(1, 4'h0, 1'b1, 1'b1, 1'b0);
        chk("t7_valid", r_valid, 1'b1);
        chk("t7_data",  r_data,  4'h0);
        chk("t7_led",   r_led,   1'b0);
        send_frame(1, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("t7b_par",  r_par,   1'b1);
        chk("t7b_valid", r_valid, 1'b0);

        // Reset after the second data bit abandons the frame
        send_bit(0, 1'b0, 1'b0);
        send_bit(0, 1'b1, 1'b0);
        send_bit(0, 1'b1, 1'b0);
        pulses = 0;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(valid_v[0]) + int'(par_v[0]) + int'(frm_v[0]);
        end
        sin_v[0] = 1'b1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            pulses += int'(valid_v[0]) + int'(par_v[0]) + int'(frm_v[0]);
        end
        chk("t8_pulses", pulses, 0);
        chk("t8_rstdata", data_a[0], 4'h0);
        $display("reset mid-frame dut0 -> pulses=%0d data=%h", pulses, data_a[0]);
        send_frame(0, 4'hA, 1'b0, 1'b1, 1'b0);
        chk("t8_valid", r_valid, 1'b1);
        chk("t8_data",  r_data,  4'hA);
        chk("t8_led",   r_led,   1'b0);

        // 300 back-to-back parity-error frames with bit_en held high
        fbits = 7'b1011010;
        pe = 0; vl = 0; fe = 0;
        @(negedge clk); bit_en = 1'b1;
        for (int f = 0; f < 300; f++) begin
            for (int b = 0; b < 7; b++) begin
                @(negedge clk);
                pe += int'(par_v[0]); vl += int'(valid_v[0]); fe += int'(frm_v[0]);
                sin_v[0] = fbits[b];
            end
        end
        repeat (8) begin
            @(negedge clk);
            sin_v[0] = 1'b1;
            pe += int'(par_v[0]); vl += int'(valid_v[0]); fe += int'(frm_v[0]);
        end
        bit_en = 1'b0;
        $display("stream dut0 300 frames -> par_err=%0d valid=%0d frm_err=%0d", pe, vl, fe);
        chk("t9_par_cnt",   pe, 300);
        chk("t9_valid_cnt", vl, 0);
        chk("t9_frm_cnt",   fe, 0);
`ifdef ERR_CNT_EN
        chk("t9_err_cnt",   cnt_a[0], 8'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
